// File: rtl/pool2x2_stream.sv
// Streaming 2x2 stride-2 max/average pooling over a raster-order pixel stream.
// A half-width line buffer carries the top-row pair result to the bottom row.
module pool2x2_stream #(
  parameter int MAX_W  = 32,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       in_width,
  input  logic [15:0]       in_height,
  input  logic              mode,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pixel,
  output logic              out_last,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for start, in_valid ignored
  // RUN   | accepting pixels, emitting pooled windows
  // DONE  | frame finished or rejected, done held high
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int BUF_D = MAX_W / 2;
  localparam int IDX_W = (BUF_D > 1) ? $clog2(BUF_D) : 1;

  state_t state_q, state_d;

  logic [15:0] w_q, h_q, row_q, col_q;
  logic        mode_q;
  logic signed [DATA_W-1:0] hold_q;
  logic signed [DATA_W:0]   lbuf [BUF_D];

  logic illegal, accept, kept, last_pix, last_win, buf_we;
  logic [15:0] col_lim, row_lim;
  logic [IDX_W-1:0] buf_idx;
  logic signed [DATA_W-1:0] pix_s, pair_max, buf_max, quad_max, result;
  logic signed [DATA_W:0]   pair_val, buf_rd;
  logic signed [DATA_W+1:0] quad_sum;

  always_comb begin
    illegal  = (in_width < 16'd2) || (in_height < 16'd2) || (in_width > 16'(MAX_W));
    accept   = (state_q == RUN) && in_valid && !start;
    col_lim  = {w_q[15:1], 1'b0};
    row_lim  = {h_q[15:1], 1'b0};
    kept     = (row_q < row_lim) && (col_q < col_lim);
    last_pix = (row_q == h_q - 16'd1) && (col_q == w_q - 16'd1);
    last_win = (row_q == row_lim - 16'd1) && (col_q == col_lim - 16'd1);
    buf_idx  = col_q[IDX_W:1];
    buf_we   = accept && kept && !row_q[0] && col_q[0];

    pix_s    = signed'(in_pixel);
    pair_max = (pix_s > hold_q) ? pix_s : hold_q;
    pair_val = mode_q ? ((DATA_W+1)'(hold_q) + (DATA_W+1)'(pix_s)) : (DATA_W+1)'(pair_max);

    // In max mode the buffer entry is a sign-extended pixel, so its low bits are exact.
    buf_rd   = lbuf[buf_idx];
    buf_max  = buf_rd[DATA_W-1:0];
    quad_max = (buf_max > pair_max) ? buf_max : pair_max;
    quad_sum = (DATA_W+2)'(buf_rd) + (DATA_W+2)'(hold_q) + (DATA_W+2)'(pix_s);
    result   = mode_q ? DATA_W'(quad_sum >>> 2) : quad_max;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = illegal ? DONE : RUN;
    end else if (state_q == RUN && accept && last_pix) begin
      state_d = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) lbuf[buf_idx] <= pair_val;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_q       <= '0;
      h_q       <= '0;
      mode_q    <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      hold_q    <= '0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      if (start) begin
        w_q    <= in_width;
        h_q    <= in_height;
        mode_q <= mode;
        row_q  <= '0;
        col_q  <= '0;
        done   <= illegal;
      end else if (accept) begin
        if (col_q == w_q - 16'd1) begin
          col_q <= '0;
          row_q <= row_q + 16'd1;
        end else begin
          col_q <= col_q + 16'd1;
        end
        if (last_pix) done <= 1'b1;
        if (kept && !col_q[0]) hold_q <= pix_s;
        if (kept && row_q[0] && col_q[0]) begin
          out_valid <= 1'b1;
          out_pixel <= result;
          out_last  <= last_win;
        end
      end
    end
  end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Randomized and directed bench for pool2x2_stream against a window-level pooling model.
module tb_pool2x2_stream;

  logic        clk = 1'b0;
  logic        reset, start, mode, in_valid;
  logic [15:0] in_width, in_height, in_pixel;
  logic        out_valid, out_last, done;
  logic [15:0] out_pixel;

  int checks = 0;
  int errors = 0;

  int frame [1024];
  int exp_val[$], exp_at[$];
  bit exp_last[$];
  int obs_val[$], obs_at[$];
  bit obs_last[$];
  int done_at, cur;

  pool2x2_stream #(.MAX_W(32), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .in_width(in_width),
    .in_height(in_height), .mode(mode), .in_valid(in_valid), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_pixel(out_pixel), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic int floor_div4(int s);
    return (s >= 0) ? s / 4 : -((-s + 3) / 4);
  endfunction

  // Reference: every full 2x2 window in raster order, the pixel index completing it, and its last flag.
  task automatic build_expected(int w, int h, bit m);
    int a, b, c, d, v;
    exp_val.delete(); exp_at.delete(); exp_last.delete();
    for (int i = 0; i < h / 2; i++)
      for (int j = 0; j < w / 2; j++) begin
        a = frame[(2*i)*w + 2*j];   b = frame[(2*i)*w + 2*j + 1];
        c = frame[(2*i+1)*w + 2*j]; d = frame[(2*i+1)*w + 2*j + 1];
        if (m) v = floor_div4(a + b + c + d);
        else begin
          v = a;
          if (b > v) v = b;
          if (c > v) v = c;
          if (d > v) v = d;
        end
        exp_val.push_back(v);
        exp_at.push_back((2*i+1)*w + 2*j + 1);
        exp_last.push_back(i == h/2 - 1 && j == w/2 - 1);
      end
  endtask

  task automatic fill_seq(int n);
    for (int k = 0; k < n; k++) frame[k] = k;
  endtask

  task automatic fill_rand(int n);
    for (int k = 0; k < n; k++) begin
      frame[k] = int'($signed(16'($urandom)));
      if ($urandom_range(7, 0) == 0) frame[k] = ($urandom_range(1, 0) == 1) ? 32767 : -32768;
    end
  endtask

  task automatic sample();
    if (out_valid === 1'b1) begin
      obs_val.push_back(int'($signed(out_pixel)));
      obs_at.push_back(cur);
      obs_last.push_back(out_last);
    end
    if (done === 1'b1 && done_at == -2) done_at = cur;
  endtask

  task automatic push_pix(int v);
    in_valid = 1'b1; in_pixel = 16'(v);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Starts a frame and streams frame[]; records outputs tagged with the last accepted pixel index.
  task automatic drive_frame(int w, int h, bit m, int minbub, int maxbub);
    int nb;
    obs_val.delete(); obs_at.delete(); obs_last.delete();
    done_at = -2; cur = -1;
    start = 1'b1; in_width = 16'(w); in_height = 16'(h); mode = m;
    @(posedge clk); @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    sample();
    for (int k = 0; k < w * h; k++) begin
      nb = (maxbub > 0) ? int'($urandom_range(maxbub, minbub)) : 0;
      repeat (nb) begin @(posedge clk); @(negedge clk); sample(); end
      in_valid = 1'b1; in_pixel = 16'(frame[k]);
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0; cur = k;
      sample();
    end
    cur = w * h;
    repeat (3) begin @(posedge clk); @(negedge clk); sample(); end
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || out_pixel !== 16'd0 || out_last !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b p=%0d l=%b d=%b want all 0", out_valid, out_pixel, out_last, done);
    end
  endtask

  task automatic test_max4x4();
    int want [4] = '{5, 7, 13, 15};
    fill_seq(16); build_expected(4, 4, 0); drive_frame(4, 4, 0, 0, 0);
    checks++;
    if (obs_val.size() !== 4) begin errors++; $display("FAIL max4x4_count got %0d want 4", obs_val.size()); end
    for (int i = 0; i < 4 && i < obs_val.size(); i++) begin
      checks++;
      if (obs_val[i] !== want[i] || obs_at[i] !== exp_at[i] || obs_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL max4x4_out%0d got val=%0d at=%0d last=%0d want val=%0d at=%0d last=%0d",
                 i, obs_val[i], obs_at[i], obs_last[i], want[i], exp_at[i], exp_last[i]);
      end
    end
    checks++;
    if (done_at !== 15) begin errors++; $display("FAIL max4x4_done got %0d want 15", done_at); end
  endtask

  task automatic test_avg4x4();
    fill_seq(16); build_expected(4, 4, 1); drive_frame(4, 4, 1, 0, 0);
    checks++;
    if (obs_val.size() !== exp_val.size()) begin errors++; $display("FAIL avg4x4_count got %0d want %0d", obs_val.size(), exp_val.size()); end
    for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
      checks++;
      if (obs_val[i] !== exp_val[i] || obs_at[i] !== exp_at[i] || obs_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL avg4x4_out%0d got val=%0d at=%0d last=%0d want val=%0d at=%0d last=%0d",
                 i, obs_val[i], obs_at[i], obs_last[i], exp_val[i], exp_at[i], exp_last[i]);
      end
    end
    checks++;
    if (done_at !== 15) begin errors++; $display("FAIL avg4x4_done got %0d want 15", done_at); end
  endtask

  task automatic test_small_signed();
    int tbl [3][4] = '{'{-1, 0, 0, 0}, '{-3, -3, -3, -3}, '{-5, -2, -7, -9}};
    int want [3] = '{-1, -3, -2};
    bit md [3] = '{1'b1, 1'b1, 1'b0};
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 4; k++) frame[k] = tbl[t][k];
      drive_frame(2, 2, md[t], 0, 0);
      checks++;
      if (obs_val.size() !== 1 || obs_val[0] !== want[t] || obs_at[0] !== 3 || obs_last[0] !== 1'b1 || done_at !== 3) begin
        errors++;
        $display("FAIL small2x2_case%0d got n=%0d val=%0d at=%0d done_at=%0d want n=1 val=%0d at=3 last=1 done_at=3",
                 t, obs_val.size(), (obs_val.size() > 0) ? obs_val[0] : 0,
                 (obs_at.size() > 0) ? obs_at[0] : 0, done_at, want[t]);
      end
    end
  endtask

  task automatic test_odd_size();
    fill_seq(15); build_expected(5, 3, 0); drive_frame(5, 3, 0, 0, 0);
    checks++;
    if (obs_val.size() !== 2) begin errors++; $display("FAIL odd_count got %0d want 2", obs_val.size()); end
    for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
      checks++;
      if (obs_val[i] !== exp_val[i] || obs_at[i] !== exp_at[i] || obs_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL odd_out%0d got val=%0d at=%0d last=%0d want val=%0d at=%0d last=%0d",
                 i, obs_val[i], obs_at[i], obs_last[i], exp_val[i], exp_at[i], exp_last[i]);
      end
    end
    checks++;
    if (done_at !== 14) begin errors++; $display("FAIL odd_done got %0d want 14", done_at); end
  endtask

  task automatic test_bubbles();
    fill_seq(16); build_expected(4, 4, 0); drive_frame(4, 4, 0, 1, 3);
    checks++;
    if (obs_val.size() !== exp_val.size()) begin errors++; $display("FAIL bubble_count got %0d want %0d", obs_val.size(), exp_val.size()); end
    for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
      checks++;
      if (obs_val[i] !== exp_val[i] || obs_at[i] !== exp_at[i] || obs_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL bubble_out%0d got val=%0d at=%0d last=%0d want val=%0d at=%0d last=%0d",
                 i, obs_val[i], obs_at[i], obs_last[i], exp_val[i], exp_at[i], exp_last[i]);
      end
    end
    checks++;
    if (done_at !== 15) begin errors++; $display("FAIL bubble_done got %0d want 15", done_at); end
  endtask

  task automatic test_ignored();
    int seen = 0;
    for (int k = 0; k < 6; k++) begin
      push_pix(int'($urandom_range(1000, 0)));
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0 || done !== 1'b1) begin
      errors++;
      $display("FAIL ignored_in_done got pulses=%0d done=%b want pulses=0 done=1", seen, done);
    end
  endtask

  task automatic test_full_width();
    int bad = 0;
    fill_seq(1024); build_expected(32, 32, 0); drive_frame(32, 32, 0, 0, 0);
    checks++;
    if (obs_val.size() !== 256) begin errors++; $display("FAIL full_count got %0d want 256", obs_val.size()); end
    for (int i = 0; i < 256 && i < obs_val.size(); i++) begin
      checks++;
      if (obs_val[i] !== (2*(i/16)+1)*32 + 2*(i%16)+1 || obs_at[i] !== exp_at[i] || obs_last[i] !== (i == 255)) begin
        errors++; bad++;
        if (bad < 5)
          $display("FAIL full_out%0d got val=%0d at=%0d last=%0d want val=%0d at=%0d last=%0d",
                   i, obs_val[i], obs_at[i], obs_last[i], (2*(i/16)+1)*32 + 2*(i%16)+1, exp_at[i], i == 255);
      end
    end
    checks++;
    if (done_at !== 1023) begin errors++; $display("FAIL full_done got %0d want 1023", done_at); end
  endtask

  task automatic test_reset_mid();
    int want [4] = '{5, 7, 13, 15};
    start = 1'b1; in_width = 16'd4; in_height = 16'd4; mode = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 6; k++) push_pix(k);
    checks++;
    if (out_valid !== 1'b1 || $signed(out_pixel) !== 16'sd5) begin
      errors++; $display("FAIL midreset_pre got v=%b p=%0d want v=1 p=5", out_valid, $signed(out_pixel));
    end
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || done !== 1'b0 || out_pixel !== 16'd0) begin
      errors++;
      $display("FAIL midreset_async got v=%b l=%b d=%b p=%0d want all 0", out_valid, out_last, done, out_pixel);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    fill_seq(16); build_expected(4, 4, 0); drive_frame(4, 4, 0, 0, 0);
    checks++;
    if (obs_val.size() !== 4) begin errors++; $display("FAIL midreset_count got %0d want 4", obs_val.size()); end
    for (int i = 0; i < 4 && i < obs_val.size(); i++) begin
      checks++;
      if (obs_val[i] !== want[i] || obs_at[i] !== exp_at[i] || obs_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL midreset_out%0d got val=%0d at=%0d last=%0d want val=%0d at=%0d last=%0d",
                 i, obs_val[i], obs_at[i], obs_last[i], want[i], exp_at[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_restart();
    start = 1'b1; in_width = 16'd4; in_height = 16'd4; mode = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) push_pix(100 + k);
    // The window-completing pixel arrives together with the restart and must be dropped.
    in_valid = 1'b1; in_pixel = 16'd999;
    frame[0] = 4; frame[1] = 8; frame[2] = -4; frame[3] = 3;
    drive_frame(2, 2, 1, 0, 0);
    checks++;
    if (obs_val.size() !== 1 || obs_val[0] !== 2 || obs_at[0] !== 3 || obs_last[0] !== 1'b1 || done_at !== 3) begin
      errors++;
      $display("FAIL restart got n=%0d val=%0d at=%0d done_at=%0d want n=1 val=2 at=3 done_at=3",
               obs_val.size(), (obs_val.size() > 0) ? obs_val[0] : 0,
               (obs_at.size() > 0) ? obs_at[0] : 0, done_at);
    end
  endtask

  task automatic test_illegal();
    int ws [3] = '{1, 4, 33};
    int hs [3] = '{4, 1, 4};
    int seen;
    for (int t = 0; t < 3; t++) begin
      start = 1'b1; in_width = 16'(ws[t]); in_height = 16'(hs[t]); mode = 1'b0;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || out_valid !== 1'b0) begin
        errors++; $display("FAIL illegal%0d_done got d=%b v=%b want d=1 v=0", t, done, out_valid);
      end
      seen = 0;
      for (int k = 0; k < 8; k++) begin push_pix(k); if (out_valid === 1'b1) seen++; end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL illegal%0d_outputs got %0d want 0", t, seen); end
    end
  endtask

  task automatic test_random();
    int w, h;
    bit m;
    for (int t = 0; t < 4; t++) begin
      w = int'($urandom_range(32, 2)); h = int'($urandom_range(7, 2)); m = 1'($urandom_range(1, 0));
      fill_rand(w * h); build_expected(w, h, m); drive_frame(w, h, m, 0, 2);
      checks++;
      if (obs_val.size() !== exp_val.size()) begin
        errors++; $display("FAIL rand%0d_count w=%0d h=%0d got %0d want %0d", t, w, h, obs_val.size(), exp_val.size());
      end
      for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
        checks++;
        if (obs_val[i] !== exp_val[i] || obs_at[i] !== exp_at[i] || obs_last[i] !== exp_last[i]) begin
          errors++;
          $display("FAIL rand%0d_out%0d mode=%0d got val=%0d at=%0d last=%0d want val=%0d at=%0d last=%0d",
                   t, i, m, obs_val[i], obs_at[i], obs_last[i], exp_val[i], exp_at[i], exp_last[i]);
        end
      end
      checks++;
      if (done_at !== w * h - 1) begin errors++; $display("FAIL rand%0d_done got %0d want %0d", t, done_at, w * h - 1); end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode = 1'b0; in_valid = 1'b0;
    in_width = '0; in_height = '0; in_pixel = '0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    begin : idle_ignore
      int seen = 0;
      for (int k = 0; k < 6; k++) begin push_pix(k + 1); if (out_valid === 1'b1 || done === 1'b1) seen++; end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL ignored_in_idle got %0d activity want 0", seen); end
    end
    test_max4x4();
    test_ignored();
    test_avg4x4();
    test_small_signed();
    test_odd_size();
    test_bubbles();
    test_full_width();
    test_reset_mid();
    test_restart();
    test_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
